// File: rtl/lutram_arb_pkg.sv
// Shared types and sizing helpers for the slice-RAM arbiter.
// Imported by lutram_arbiter and rr_arbiter.
package lutram_arb_pkg;

  typedef enum logic {ST_CLEAR, ST_ARB} state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // A one-requester pointer still needs a 1-bit register.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

  function automatic int unsigned depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after i_ptr,
// wrapping explicitly at NUM_REQ-1 so non-power-of-two counts work.
module rr_arbiter
  import lutram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PTR_W-1:0]   o_idx
);

  localparam int unsigned JW = PTR_W + 1;

  logic          w_found;
  logic [JW-1:0] w_j;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      w_j = {1'b0, i_ptr} + JW'(k);
      if (w_j >= JW'(NUM_REQ)) w_j = w_j - JW'(NUM_REQ);
      if (i_en && !w_found && i_req[w_j[PTR_W-1:0]]) begin
        w_found                 = 1'b1;
        o_gnt[w_j[PTR_W-1:0]]   = 1'b1;
        o_idx                   = w_j[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/lutram_arbiter.sv
// Clears a 16xN distributed RAM after reset, then grants one read or write
// per cycle round-robin and returns registered read data.
module lutram_arbiter
  import lutram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = 4,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_we,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_rvalid,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_busy,
  output logic [ADDR_W-1:0]         o_ram_wad,
  output logic [DATA_W-1:0]         o_ram_di,
  output logic                      o_ram_wre,
  output logic [ADDR_W-1:0]         o_ram_rad,
  input  logic [DATA_W-1:0]         i_ram_do
);

  localparam int unsigned PTR_W = ptr_width(NUM_REQ);
  localparam int unsigned DEPTH = depth(ADDR_W);

  state_e              r_state;
  logic [PTR_W-1:0]    r_ptr;
  logic [ADDR_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0]  r_rvalid;
  logic [DATA_W-1:0]   r_rdata;

  logic [ADDR_W-1:0]   w_addr  [NUM_REQ];
  logic [DATA_W-1:0]   w_wdata [NUM_REQ];
  logic [NUM_REQ-1:0]  w_gnt;
  logic [PTR_W-1:0]    w_idx;
  logic                w_arb_en;
  logic                w_any;
  logic                w_wr_grant;
  logic                w_rd_grant;
  logic [PTR_W-1:0]    w_rad_idx;
  logic [PTR_W-1:0]    w_ptr_next;

  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
    assign w_addr[g]  = i_addr[g*ADDR_W +: ADDR_W];
    assign w_wdata[g] = i_wdata[g*DATA_W +: DATA_W];
  end

  assign w_arb_en = i_rstn && (r_state == ST_ARB);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_any      = |w_gnt;
  assign w_wr_grant = w_any && i_we[w_idx];
  assign w_rd_grant = w_any && !i_we[w_idx];
  // Idle read port follows the pointer so RAM_RAD never floats to X.
  assign w_rad_idx  = w_rd_grant ? w_idx : r_ptr;
  assign w_ptr_next = (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + PTR_W'(1);

  always_comb begin
    o_gnt     = w_gnt;
    o_busy    = (r_state == ST_CLEAR);
    o_ram_rad = w_addr[w_rad_idx];
    o_ram_wre = 1'b0;
    o_ram_wad = w_addr[w_idx];
    o_ram_di  = w_wdata[w_idx];
    if (r_state == ST_CLEAR) begin
      o_ram_wre = i_rstn;
      o_ram_wad = r_cnt;
      o_ram_di  = '0;
    end else begin
      o_ram_wre = w_wr_grant;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state  <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= '0;
      case (r_state)
        ST_CLEAR: begin
          r_cnt <= r_cnt + ADDR_W'(1);
          if (r_cnt == ADDR_W'(DEPTH - 1)) r_state <= ST_ARB;
        end
        default: begin
          if (w_any) begin
            r_ptr <= w_ptr_next;
            if (w_rd_grant) begin
              r_rdata  <= i_ram_do;
              r_rvalid <= w_gnt;
            end
          end
        end
      endcase
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;

endmodule

// File: tb/tb_lutram_arbiter.sv
// Bench for lutram_arbiter: clear sequence, directed vector table, reset
// corner cases, then random traffic against a behavioural model.
module tb_lutram_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR-1:0]    we = '0;
  logic [NR*AW-1:0] addr = '0;
  logic [NR*DW-1:0] wdata = '0;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    rvalid;
  logic [DW-1:0]    rdata;
  logic             busy;
  logic [AW-1:0]    ram_wad;
  logic [DW-1:0]    ram_di;
  logic             ram_wre;
  logic [AW-1:0]    ram_rad;
  logic [DW-1:0]    ram_do;

  lutram_arbiter #(
    .NUM_REQ        (NR),
    .DATA_W         (DW),
    .ADDR_W         (AW),
    .CLEAR_ON_RESET (1)
  ) dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_req     (req),
    .i_we      (we),
    .i_addr    (addr),
    .i_wdata   (wdata),
    .o_gnt     (gnt),
    .o_rvalid  (rvalid),
    .o_rdata   (rdata),
    .o_busy    (busy),
    .o_ram_wad (ram_wad),
    .o_ram_di  (ram_di),
    .o_ram_wre (ram_wre),
    .o_ram_rad (ram_rad),
    .i_ram_do  (ram_do)
  );

  // Slice RAM: synchronous write, asynchronous read.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) if (ram_wre) ram[ram_wad] <= ram_di;
  assign ram_do = ram[ram_rad];

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NR-1:0]    req;
    logic [NR-1:0]    we;
    logic [NR*AW-1:0] addr;
    logic [NR*DW-1:0] wdata;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    rv;
    logic [DW-1:0]    rd;
  } vec_t;

  vec_t tbl [16];

  // Behavioural model state for the random phase.
  logic [NR-1:0] p_req;
  logic [NR-1:0] p_we;
  logic [AW-1:0] p_addr [NR];
  logic [DW-1:0] p_wd [NR];
  logic [DW-1:0] mem_m [DEPTH];
  logic [NR-1:0] rv_m;
  logic [DW-1:0] rd_m;
  logic [NR-1:0] exp_gnt;
  logic [AW-1:0] exp_rad;
  int            ptr_m;
  int            winner;
  int            j;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom());

    tbl[0]  = '{4'b0100, 4'b0000, 16'h0700, 16'h0000, 4'b0100, 4'b0000, 4'h0};
    tbl[1]  = '{4'b0001, 4'b0001, 16'h0003, 16'h000A, 4'b0001, 4'b0100, 4'h0};
    tbl[2]  = '{4'b0010, 4'b0000, 16'h0030, 16'h0000, 4'b0010, 4'b0000, 4'h0};
    tbl[3]  = '{4'b1010, 4'b1010, 16'h6050, 16'h2010, 4'b1000, 4'b0010, 4'hA};
    tbl[4]  = '{4'b1010, 4'b1010, 16'h6050, 16'h2010, 4'b0010, 4'b0000, 4'hA};
    tbl[5]  = '{4'b1010, 4'b1010, 16'h6050, 16'h2010, 4'b1000, 4'b0000, 4'hA};
    tbl[6]  = '{4'b1111, 4'b0000, 16'h7365, 16'h0000, 4'b0001, 4'b0000, 4'hA};
    tbl[7]  = '{4'b1111, 4'b0000, 16'h7365, 16'h0000, 4'b0010, 4'b0001, 4'h1};
    tbl[8]  = '{4'b1111, 4'b0000, 16'h7365, 16'h0000, 4'b0100, 4'b0010, 4'h2};
    tbl[9]  = '{4'b1111, 4'b0000, 16'h7365, 16'h0000, 4'b1000, 4'b0100, 4'hA};
    tbl[10] = '{4'b1111, 4'b0000, 16'h7365, 16'h0000, 4'b0001, 4'b1000, 4'h0};
    tbl[11] = '{4'b1111, 4'b0000, 16'h7365, 16'h0000, 4'b0010, 4'b0001, 4'h1};
    tbl[12] = '{4'b1111, 4'b0000, 16'h7365, 16'h0000, 4'b0100, 4'b0010, 4'h2};
    tbl[13] = '{4'b1111, 4'b0000, 16'h7365, 16'h0000, 4'b1000, 4'b0100, 4'hA};
    tbl[14] = '{4'b0000, 4'b0000, 16'h7365, 16'h0000, 4'b0000, 4'b1000, 4'h0};
    tbl[15] = '{4'b0000, 4'b0000, 16'h7365, 16'h0000, 4'b0000, 4'b0000, 4'h0};

    // Reset with requests pending: grant and write enable must stay low.
    rstn = 1'b0;
    req  = 4'b1111;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_wre", 32'(ram_wre), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);

    // Clear sequence: 16 cycles writing zero, requests ignored.
    rstn = 1'b1;
    #1;
    for (int c = 0; c < DEPTH; c++) begin
      chk("clr_busy", 32'(busy), 32'h1);
      chk("clr_wre", 32'(ram_wre), 32'h1);
      chk("clr_wad", 32'(ram_wad), 32'(c));
      chk("clr_di", 32'(ram_di), 32'h0);
      chk("clr_gnt", 32'(gnt), 32'h0);
      tick();
    end
    chk("clr_done_busy", 32'(busy), 32'h0);

    // Directed vectors, one row per cycle.
    for (int i = 0; i < 16; i++) begin
      req   = tbl[i].req;
      we    = tbl[i].we;
      addr  = tbl[i].addr;
      wdata = tbl[i].wdata;
      #1;
      chk("vec_gnt", 32'(gnt), 32'(tbl[i].gnt));
      chk("vec_rvalid", 32'(rvalid), 32'(tbl[i].rv));
      chk("vec_rdata", 32'(rdata), 32'(tbl[i].rd));
      tick();
    end

    // Reset during the clear at counter 9 restarts a full 16-cycle clear.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    chk("mid_clr_wad", 32'(ram_wad), 32'h9);
    rstn = 1'b0;
    #1;
    chk("mid_clr_wre_rst", 32'(ram_wre), 32'h0);
    tick();
    rstn = 1'b1;
    #1;
    chk("reclr_busy", 32'(busy), 32'h1);
    chk("reclr_rvalid", 32'(rvalid), 32'h0);
    for (int c = 0; c < DEPTH; c++) begin
      chk("reclr_wad", 32'(ram_wad), 32'(c));
      chk("reclr_busy_n", 32'(busy), 32'h1);
      tick();
    end
    chk("reclr_done", 32'(busy), 32'h0);

    // Write 5 to addr 2, read it back, then reset on the next read edge.
    req   = 4'b0001;
    we    = 4'b0001;
    addr  = 16'h0002;
    wdata = 16'h0005;
    tick();
    we = 4'b0000;
    tick();
    chk("rb_rvalid", 32'(rvalid), 32'h1);
    chk("rb_rdata", 32'(rdata), 32'h5);
    rstn = 1'b0;
    #1;
    chk("rst_read_gnt", 32'(gnt), 32'h0);
    tick();
    rstn = 1'b1;
    req  = 4'b0000;
    #1;
    chk("abort_rvalid", 32'(rvalid), 32'h0);
    chk("abort_rdata", 32'(rdata), 32'h0);
    chk("abort_busy", 32'(busy), 32'h1);
    chk("abort_wad", 32'(ram_wad), 32'h0);
    for (int k = 0; k < DEPTH; k++) tick();
    chk("abort_done", 32'(busy), 32'h0);

    // Random traffic against a model of the arbitration rules.
    ptr_m = 0;
    rv_m  = '0;
    rd_m  = '0;
    p_req = '0;
    p_we  = '0;
    for (int i = 0; i < NR; i++) begin
      p_addr[i] = '0;
      p_wd[i]   = '0;
    end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (!p_req[i] && $urandom_range(0, 2) != 0) begin
          p_req[i]  = 1'b1;
          p_we[i]   = 1'($urandom_range(0, 1));
          p_addr[i] = AW'($urandom_range(0, DEPTH - 1));
          p_wd[i]   = DW'($urandom());
        end
      end
      req = p_req;
      we  = p_we;
      for (int i = 0; i < NR; i++) begin
        addr[i*AW +: AW]  = p_addr[i];
        wdata[i*DW +: DW] = p_wd[i];
      end
      #1;

      winner = -1;
      for (int k = 0; k < NR; k++) begin
        j = (ptr_m + k) % NR;
        if (winner < 0 && p_req[j]) winner = j;
      end
      exp_gnt = (winner >= 0) ? (NR'(1) << winner) : '0;
      exp_rad = (winner >= 0 && !p_we[winner]) ? p_addr[winner] : p_addr[ptr_m];

      chk("rnd_gnt", 32'(gnt), 32'(exp_gnt));
      chk("rnd_rvalid", 32'(rvalid), 32'(rv_m));
      chk("rnd_rdata", 32'(rdata), 32'(rd_m));
      chk("rnd_rad", 32'(ram_rad), 32'(exp_rad));
      chk("rnd_wre", 32'(ram_wre), 32'(winner >= 0 && p_we[winner]));
      if (winner >= 0 && p_we[winner]) begin
        chk("rnd_wad", 32'(ram_wad), 32'(p_addr[winner]));
        chk("rnd_di", 32'(ram_di), 32'(p_wd[winner]));
      end

      rv_m = '0;
      if (winner >= 0) begin
        if (p_we[winner]) begin
          mem_m[p_addr[winner]] = p_wd[winner];
        end else begin
          rv_m = exp_gnt;
          rd_m = mem_m[p_addr[winner]];
        end
        ptr_m = (winner + 1) % NR;
        p_req[winner] = 1'b0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
